// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Brief    : Shared types, ASCII constants and helpers for the UART command
//            sequencer.
// Revision : 1.0  initial release
// ============================================================================
package uart_cmd_pkg;

  // Parser state; explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D_MT = 3'd1,
    ST_D_MO = 3'd2,
    ST_D_ST = 3'd3,
    ST_D_SO = 3'd4,
    ST_W_CR = 3'd5
  } state_e;

  localparam logic [7:0] CMD_TIME_L  = 8'h6c;  // 'l'
  localparam logic [7:0] CMD_TIME_U  = 8'h4c;  // 'L'
  localparam logic [7:0] CMD_ALARM_L = 8'h61;  // 'a'
  localparam logic [7:0] CMD_ALARM_U = 8'h41;  // 'A'
  localparam logic [7:0] CMD_TOGGLE  = 8'h40;  // '@'
  localparam logic [7:0] CR          = 8'h0d;
  localparam logic [7:0] ERR_CHAR    = 8'h3f;  // '?'
  localparam logic [7:0] ASCII_ZERO  = 8'h30;  // '0'

  localparam logic CMD_TYPE_TIME  = 1'b0;
  localparam logic CMD_TYPE_ALARM = 1'b1;

  // True when b is an ASCII digit in the range '0'..('0'+max)
  function automatic logic ascii_digit_ok(input logic [7:0] b, input logic [3:0] max);
    return (b >= ASCII_ZERO) && (b <= (ASCII_ZERO + {4'h0, max}));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with synchronous reset. A push while full is
//            accepted only if a pop happens in the same cycle. Read data is
//            the head entry, valid whenever o_empty is low.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of two, at least 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (cnt_q == CW'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_dout  = mem_q[rd_q];

  // Accept/pointer arithmetic; pointers wrap naturally at a power-of-two depth
  always_comb begin
    w_do_pop  = i_pop && !o_empty;
    w_do_push = i_push && (!o_full || w_do_pop);
    wr_d      = wr_q + AW'(w_do_push);
    rd_d      = rd_q + AW'(w_do_pop);
    cnt_d     = cnt_q + CW'(w_do_push) - CW'(w_do_pop);
    mem_d     = mem_q;
    if (w_do_push) begin
      mem_d[wr_q] = i_din;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_sequencer
// Brief    : Parses UART command bytes ('l'/'L' time, 'a'/'A' alarm, '@'
//            toggle), validates MM:SS digits, pulses load strobes with BCD
//            digits and echoes accepted bytes ('?' on error) via a FIFO.
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT    = 12000000,
  parameter int TO_W       = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk12m,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_rdy,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_data_rdy,
  output logic       ld_time,
  output logic       ld_alarm,
  output logic [3:0] dig_mt,
  output logic [3:0] dig_mo,
  output logic [3:0] dig_st,
  output logic [3:0] dig_so,
  output logic       alarm_en,
  output logic       cmd_err,
  output logic       busy,
  output logic       tx_drop
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            type_q, type_d;
  logic [3:0]      sh_mt_q, sh_mt_d, sh_mo_q, sh_mo_d;
  logic [3:0]      sh_st_q, sh_st_d, sh_so_q, sh_so_d;
  logic [3:0]      dig_mt_q, dig_mt_d, dig_mo_q, dig_mo_d;
  logic [3:0]      dig_st_q, dig_st_d, dig_so_q, dig_so_d;
  logic            alarm_en_q, alarm_en_d;
  logic            ld_time_q, ld_time_d;
  logic            ld_alarm_q, ld_alarm_d;
  logic            cmd_err_q, cmd_err_d;
  logic            busy_q, busy_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_data_rdy_q, tx_data_rdy_d;
  logic            tx_drop_q, tx_drop_d;

  logic            w_err;
  logic            w_push;
  logic [7:0]      w_push_data;
  logic            w_pop;
  logic [7:0]      w_fifo_dout;
  logic            w_fifo_full;
  logic            w_fifo_empty;

  // Parser next-state, shadow/digit updates, strobes and echo selection
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    sh_mt_d     = sh_mt_q;
    sh_mo_d     = sh_mo_q;
    sh_st_d     = sh_st_q;
    sh_so_d     = sh_so_q;
    dig_mt_d    = dig_mt_q;
    dig_mo_d    = dig_mo_q;
    dig_st_d    = dig_st_q;
    dig_so_d    = dig_so_q;
    alarm_en_d  = alarm_en_q;
    ld_time_d   = 1'b0;
    ld_alarm_d  = 1'b0;
    cmd_err_d   = 1'b0;
    w_err       = 1'b0;
    w_push      = 1'b0;
    w_push_data = rx_data;

    // Low nibble of an ASCII digit is its BCD value
    if (rx_data_rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == CMD_TIME_L || rx_data == CMD_TIME_U) begin
            type_d  = CMD_TYPE_TIME;
            state_d = ST_D_MT;
            w_push  = 1'b1;
          end else if (rx_data == CMD_ALARM_L || rx_data == CMD_ALARM_U) begin
            type_d  = CMD_TYPE_ALARM;
            state_d = ST_D_MT;
            w_push  = 1'b1;
          end else if (rx_data == CMD_TOGGLE) begin
            alarm_en_d = !alarm_en_q;
            w_push     = 1'b1;
          end
        end
        ST_D_MT: begin
          if (ascii_digit_ok(rx_data, 4'd5)) begin
            sh_mt_d = rx_data[3:0];
            state_d = ST_D_MO;
            w_push  = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_D_MO: begin
          if (ascii_digit_ok(rx_data, 4'd9)) begin
            sh_mo_d = rx_data[3:0];
            state_d = ST_D_ST;
            w_push  = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_D_ST: begin
          if (ascii_digit_ok(rx_data, 4'd5)) begin
            sh_st_d = rx_data[3:0];
            state_d = ST_D_SO;
            w_push  = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_D_SO: begin
          if (ascii_digit_ok(rx_data, 4'd9)) begin
            sh_so_d = rx_data[3:0];
            state_d = ST_W_CR;
            w_push  = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        ST_W_CR: begin
          if (rx_data == CR) begin
            dig_mt_d   = sh_mt_q;
            dig_mo_d   = sh_mo_q;
            dig_st_d   = sh_st_q;
            dig_so_d   = sh_so_q;
            ld_time_d  = (type_q == CMD_TYPE_TIME);
            ld_alarm_d = (type_q == CMD_TYPE_ALARM);
            state_d    = ST_IDLE;
            w_push     = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && to_q == TO_LAST) begin
      // Timeout only fires when no byte arrives on the expiry cycle
      w_err = 1'b1;
    end

    if (w_err) begin
      cmd_err_d   = 1'b1;
      w_push      = 1'b1;
      w_push_data = ERR_CHAR;
      state_d     = ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Timeout counter, transmit handshake and drop flag
  always_comb begin
    if (state_d == ST_IDLE || rx_data_rdy) begin
      to_d = '0;
    end else begin
      to_d = to_q + TO_W'(1);
    end
    // A strobe is never followed directly by another, giving tx_busy a cycle to rise
    w_pop         = !w_fifo_empty && !tx_busy && !tx_data_rdy_q;
    tx_data_rdy_d = w_pop;
    tx_data_d     = w_pop ? w_fifo_dout : tx_data_q;
    tx_drop_d     = tx_drop_q || (w_push && w_fifo_full && !w_pop);
  end

  // State and output registers
  always_ff @(posedge clk12m) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      type_q        <= CMD_TYPE_TIME;
      sh_mt_q       <= '0;
      sh_mo_q       <= '0;
      sh_st_q       <= '0;
      sh_so_q       <= '0;
      dig_mt_q      <= '0;
      dig_mo_q      <= '0;
      dig_st_q      <= '0;
      dig_so_q      <= '0;
      alarm_en_q    <= 1'b0;
      ld_time_q     <= 1'b0;
      ld_alarm_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      to_q          <= '0;
      tx_data_q     <= '0;
      tx_data_rdy_q <= 1'b0;
      tx_drop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      sh_mt_q       <= sh_mt_d;
      sh_mo_q       <= sh_mo_d;
      sh_st_q       <= sh_st_d;
      sh_so_q       <= sh_so_d;
      dig_mt_q      <= dig_mt_d;
      dig_mo_q      <= dig_mo_d;
      dig_st_q      <= dig_st_d;
      dig_so_q      <= dig_so_d;
      alarm_en_q    <= alarm_en_d;
      ld_time_q     <= ld_time_d;
      ld_alarm_q    <= ld_alarm_d;
      cmd_err_q     <= cmd_err_d;
      busy_q        <= busy_d;
      to_q          <= to_d;
      tx_data_q     <= tx_data_d;
      tx_data_rdy_q <= tx_data_rdy_d;
      tx_drop_q     <= tx_drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_echo_fifo (
    .clk     (clk12m),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_push_data),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign tx_data     = tx_data_q;
  assign tx_data_rdy = tx_data_rdy_q;
  assign ld_time     = ld_time_q;
  assign ld_alarm    = ld_alarm_q;
  assign dig_mt      = dig_mt_q;
  assign dig_mo      = dig_mo_q;
  assign dig_st      = dig_st_q;
  assign dig_so      = dig_so_q;
  assign alarm_en    = alarm_en_q;
  assign cmd_err     = cmd_err_q;
  assign busy        = busy_q;
  assign tx_drop     = tx_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_sequencer
// Brief    : Directed, table-driven bench for uart_cmd_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_sequencer;

  logic       clk12m = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_rdy = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_data_rdy, ld_time, ld_alarm, alarm_en, cmd_err, busy, tx_drop;
  logic [3:0] dig_mt, dig_mo, dig_st, dig_so;

  uart_cmd_sequencer #(
    .TIMEOUT    (16),
    .TO_W       (24),
    .FIFO_DEPTH (4)
  ) dut (
    .clk12m      (clk12m),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_data_rdy (rx_data_rdy),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_data_rdy (tx_data_rdy),
    .ld_time     (ld_time),
    .ld_alarm    (ld_alarm),
    .dig_mt      (dig_mt),
    .dig_mo      (dig_mo),
    .dig_st      (dig_st),
    .dig_so      (dig_so),
    .alarm_en    (alarm_en),
    .cmd_err     (cmd_err),
    .busy        (busy),
    .tx_drop     (tx_drop)
  );

  always #5 clk12m = ~clk12m;

  typedef struct {
    logic [7:0]  rx;
    logic        busy;
    logic        err;
    logic        ldt;
    logic        lda;
    logic        aen;
    logic [15:0] dig;
    logic [7:0]  echo;  // 0 means no echo expected
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_tx[$];
  logic [7:0] tx_log[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         cyc = 0;
  int         last_tx = -10;
  int         gap_viol = 0;
  int         err_cnt = 0;
  int         lda_cnt = 0;

  always @(posedge clk12m) cyc <= cyc + 1;

  // Passive monitor of strobes on the falling edge
  always @(negedge clk12m) begin
    if (tx_data_rdy === 1'b1) begin
      tx_log.push_back(tx_data);
      if (cyc - last_tx < 2) gap_viol <= gap_viol + 1;
      last_tx <= cyc;
    end
    if (cmd_err === 1'b1) err_cnt <= err_cnt + 1;
    if (ld_alarm === 1'b1) lda_cnt <= lda_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic [7:0] rx, input logic b, input logic e, input logic lt,
                     input logic la, input logic ae, input logic [15:0] d, input logic [7:0] ec);
    vec_t v;
    v.rx = rx; v.busy = b; v.err = e; v.ldt = lt; v.lda = la; v.aen = ae; v.dig = d; v.echo = ec;
    vecs.push_back(v);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk12m);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_data_rdy = 1'b1;
    tick(1);
    rx_data_rdy = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic check_tx(input string name, input int base, input logic [7:0] exp[$]);
    check({name, "_count"}, tx_log.size() - base, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (base + i < tx_log.size()) check(name, {24'h0, tx_log[base + i]}, {24'h0, exp[i]});
    end
  endtask

  function automatic logic [30:0] all_outs();
    return {tx_data, tx_data_rdy, ld_time, ld_alarm, dig_mt, dig_mo, dig_st, dig_so,
            alarm_en, cmd_err, busy, tx_drop};
  endfunction

  initial begin
    int base;
    int err0;
    int lda0;
    logic [7:0] q[$];

    // Table: byte, busy, cmd_err, ld_time, ld_alarm, alarm_en, digits, echo
    add("l",   1, 0, 0, 0, 0, 16'h0000, "l");
    add("5",   1, 0, 0, 0, 0, 16'h0000, "5");
    add("9",   1, 0, 0, 0, 0, 16'h0000, "9");
    add("1",   1, 0, 0, 0, 0, 16'h0000, "1");
    add("0",   1, 0, 0, 0, 0, 16'h0000, "0");
    add(8'h0d, 0, 0, 1, 0, 0, 16'h5910, 8'h0d);
    add("A",   1, 0, 0, 0, 0, 16'h5910, "A");
    add("5",   1, 0, 0, 0, 0, 16'h5910, "5");
    add("9",   1, 0, 0, 0, 0, 16'h5910, "9");
    add("5",   1, 0, 0, 0, 0, 16'h5910, "5");
    add("9",   1, 0, 0, 0, 0, 16'h5910, "9");
    add(8'h0d, 0, 0, 0, 1, 0, 16'h5959, 8'h0d);
    add("@",   0, 0, 0, 0, 1, 16'h5959, "@");
    add("@",   0, 0, 0, 0, 0, 16'h5959, "@");
    add("l",   1, 0, 0, 0, 0, 16'h5959, "l");
    add("6",   0, 1, 0, 0, 0, 16'h5959, "?");
    add("x",   0, 0, 0, 0, 0, 16'h5959, 8'h00);
    add(8'h0d, 0, 0, 0, 0, 0, 16'h5959, 8'h00);
    add("L",   1, 0, 0, 0, 0, 16'h5959, "L");
    add("2",   1, 0, 0, 0, 0, 16'h5959, "2");
    add("3",   1, 0, 0, 0, 0, 16'h5959, "3");
    add("4",   1, 0, 0, 0, 0, 16'h5959, "4");
    add("5",   1, 0, 0, 0, 0, 16'h5959, "5");
    add("z",   0, 1, 0, 0, 0, 16'h5959, "?");
    add("a",   1, 0, 0, 0, 0, 16'h5959, "a");
    add("5",   1, 0, 0, 0, 0, 16'h5959, "5");
    add("a",   0, 1, 0, 0, 0, 16'h5959, "?");
    add("l",   1, 0, 0, 0, 0, 16'h5959, "l");
    add("0",   1, 0, 0, 0, 0, 16'h5959, "0");
    add("0",   1, 0, 0, 0, 0, 16'h5959, "0");
    add("0",   1, 0, 0, 0, 0, 16'h5959, "0");
    add("0",   1, 0, 0, 0, 0, 16'h5959, "0");
    add(8'h0d, 0, 0, 1, 0, 0, 16'h0000, 8'h0d);
    add("a",   1, 0, 0, 0, 0, 16'h0000, "a");
    add("0",   1, 0, 0, 0, 0, 16'h0000, "0");
    add("9",   1, 0, 0, 0, 0, 16'h0000, "9");
    add("5",   1, 0, 0, 0, 0, 16'h0000, "5");
    add("9",   1, 0, 0, 0, 0, 16'h0000, "9");
    add(8'h0d, 0, 0, 0, 1, 0, 16'h0959, 8'h0d);
    add("@",   0, 0, 0, 0, 1, 16'h0959, "@");

    // Reset state
    tick(3);
    check("reset_outputs", {1'b0, all_outs()}, 32'h0);
    rst = 1'b0;
    tick(1);

    // Table-driven parsing with one idle cycle between bytes
    base = tx_log.size();
    foreach (vecs[i]) begin
      send_byte(vecs[i].rx);
      check($sformatf("vec%0d", i),
            {11'h0, busy, cmd_err, ld_time, ld_alarm, alarm_en, dig_mt, dig_mo, dig_st, dig_so},
            {11'h0, vecs[i].busy, vecs[i].err, vecs[i].ldt, vecs[i].lda, vecs[i].aen, vecs[i].dig});
      if (vecs[i].echo != 8'h00) exp_tx.push_back(vecs[i].echo);
      tick(1);
    end
    tick(10);
    check_tx("table_echo", base, exp_tx);
    check("no_drop_table", {31'h0, tx_drop}, 32'h0);

    // Timeout: 16 idle cycles after the last byte abort the command
    base = tx_log.size();
    send_byte("l"); tick(1);
    send_byte("1"); tick(1);
    send_byte("2");
    tick(15);
    check("to_before_expiry", {30'h0, busy, cmd_err}, 32'h2);
    tick(1);
    check("to_expiry", {30'h0, busy, cmd_err}, 32'h1);
    tick(8);
    q = '{8'h6c, 8'h31, 8'h32, 8'h3f};
    check_tx("to_echo", base, q);

    // A byte on the expiry cycle wins over the timeout
    err0 = err_cnt;
    send_byte("l"); tick(1);
    send_byte("2"); tick(1);
    send_byte("0");
    tick(15);
    send_byte("4");
    check("to_byte_wins", {30'h0, busy, cmd_err}, 32'h2);
    tick(1);
    send_byte("7"); tick(1);
    send_byte(8'h0d);
    check("to_load", {15'h0, ld_time, dig_mt, dig_mo, dig_st, dig_so}, {15'h0, 1'b1, 16'h2047});
    check("to_no_err", err_cnt - err0, 0);
    tick(12);

    // Echo FIFO overflow while the transmitter is busy
    tx_busy = 1'b1;
    base = tx_log.size();
    send_byte("l");
    send_byte("1");
    send_byte("2");
    send_byte("3");
    send_byte("4");
    send_byte(8'h0d);
    check("ovf_load", {15'h0, ld_time, dig_mt, dig_mo, dig_st, dig_so}, {15'h0, 1'b1, 16'h1234});
    check("ovf_drop", {31'h0, tx_drop}, 32'h1);
    check("ovf_held", tx_log.size() - base, 0);
    tick(2);
    tx_busy = 1'b0;
    tick(12);
    q = '{8'h6c, 8'h31, 8'h32, 8'h33};
    check_tx("ovf_echo", base, q);
    check("drop_sticky", {31'h0, tx_drop}, 32'h1);
    check("tx_gap", gap_viol, 0);

    // Reset mid-command discards it
    send_byte("a"); tick(1);
    send_byte("1"); tick(1);
    send_byte("2");
    rst = 1'b1;
    tick(2);
    check("rst_mid_outputs", {1'b0, all_outs()}, 32'h0);
    rst = 1'b0;
    tick(1);
    lda0 = lda_cnt;
    send_byte("l"); tick(1);
    send_byte("0"); tick(1);
    send_byte("0"); tick(1);
    send_byte("0"); tick(1);
    send_byte("0"); tick(1);
    send_byte(8'h0d);
    check("rst_after_load", {13'h0, ld_time, ld_alarm, busy, dig_mt, dig_mo, dig_st, dig_so},
          {13'h0, 1'b1, 1'b0, 1'b0, 16'h0000});
    tick(2);
    check("rst_no_alarm_ld", lda_cnt - lda0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
Command sequencer between the UART receive path and the alarm-clock datapath of the lab 3 design.
- Parses ASCII command bytes: 'l'/'L' load time, 'a'/'A' load alarm, '@' toggle alarm enable.
- Validates four MM:SS digits and issues one-cycle load strobes with BCD digits to the time/alarm registers.
- Echoes accepted bytes, and '?' on errors, back to the UART transmitter through a small FIFO.

Parameters:
TIMEOUT, 12000000, idle cycles allowed mid-command before abort (1 s at 12 MHz); benches use 16.
TO_W, 24, width of the timeout counter; must satisfy TIMEOUT < 2**TO_W.
FIFO_DEPTH, 4, echo FIFO entries (power of two).

Ports:
clk12m  input  1  12 MHz clock.
rst  input  1  synchronous active-high reset.
rx_data  input  8  received byte.
rx_data_rdy  input  1  one-cycle valid strobe for rx_data.
tx_busy  input  1  UART transmitter busy.
tx_data  output  8  byte to transmit.
tx_data_rdy  output  1  one-cycle transmit strobe.
ld_time  output  1  one-cycle load strobe for the time register.
ld_alarm  output  1  one-cycle load strobe for the alarm register.
dig_mt  output  4  minutes tens, BCD.
dig_mo  output  4  minutes ones, BCD.
dig_st  output  4  seconds tens, BCD.
dig_so  output  4  seconds ones, BCD.
alarm_en  output  1  alarm enable level.
cmd_err  output  1  one-cycle error strobe.
busy  output  1  high while the FSM is not in IDLE.
tx_drop  output  1  sticky flag: an echo was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, timeout counter 0. Reset mid-command discards the partial command; no strobe is issued.
- All outputs are registered. A byte sampled at edge N produces its response at edge N+1.
- FSM states: IDLE, D_MT, D_MO, D_ST, D_SO, W_CR. A 1-bit register records the command type (time or alarm).
- IDLE transitions:
  - 'l'/'L' -> D_MT with type time.
  - 'a'/'A' -> D_MT with type alarm.
  - '@' toggles alarm_en and stays in IDLE.
  - 0x0d and all other bytes are ignored: no echo, no error.
- Digit states:
  - D_MT and D_ST accept '0'..'5'.
  - D_MO and D_SO accept '0'..'9'.
  - A valid digit is stored as byte-0x30 in a shadow register and the FSM advances. The D_SO digit advances to W_CR.
- W_CR: 0x0d copies the shadow registers to dig_* and pulses ld_time or ld_alarm for one cycle (together with the new digits), then returns to IDLE.
- Invalid byte in any digit state or W_CR: cmd_err pulse, '?' pushed, the bad byte is not echoed, return to IDLE, shadow registers discarded, dig_* unchanged.
- Echo: every byte that changes state or is accepted is pushed to the FIFO. This covers command letters, valid digits, CR in W_CR, and '@'. At most one push per cycle.
- Timeout:
  - The counter reloads to 0 on every rx_data_rdy and counts while busy.
  - When it reaches TIMEOUT-1: return to IDLE, cmd_err pulse, '?' pushed.
  - If rx_data_rdy arrives in the same cycle, the byte wins and the counter reloads.
  - The counter is held at 0 in IDLE.
- FIFO:
  - Push when full: the byte is dropped and tx_drop is set until reset. Parsing is unaffected.
  - Simultaneous push and pop when full: both succeed.
- Transmit handshake:
  - When the FIFO is non-empty and tx_busy=0, pop, drive tx_data and pulse tx_data_rdy for one cycle.
  - Minimum one idle cycle between strobes, so tx_busy has one cycle to rise.
  - Bytes go out in FIFO order.
- dig_* hold their values between loads. Command letters are case-insensitive.

Decomposition:
- Shared package uart_cmd_pkg:
  - FSM state enum.
  - ASCII constants: CMD_TIME_L/U, CMD_ALARM_L/U, CMD_TOGGLE='@', CR=8'h0d, ERR_CHAR='?'.
  - Function ascii_digit_ok(byte, max).
- One sub-module: sync_fifo. Parameterised width/depth, push/pop/full/empty, same clock and synchronous reset.

Test Plan:
1. Send "l5910"+0x0d, tx_busy=0 -> one cycle after the CR: ld_time=1 and dig_mt/mo/st/so=5/9/1/0 in the same cycle. tx_data sequence 'l','5','9','1','0',0x0d. cmd_err never asserted.
2. Send "A5959"+0x0d then '@' -> ld_alarm pulse with 5/9/5/9, ld_time stays 0, alarm_en 0->1. A second '@' -> alarm_en 1->0.
3. Send "l6" -> cmd_err pulse after '6', FSM returns to IDLE, dig_* unchanged, tx sequence 'l','?'. A following "l0000"+0x0d loads 0/0/0/0.
4. TIMEOUT=16: send "l12", then 16 idle cycles -> cmd_err and '?' pushed, busy=0. A byte arriving on the expiry cycle instead continues the command with no error.
5. tx_busy held 1: send "l1234"+0x0d (6 echoes) -> first 4 queued, tx_drop=1, ld_time still pulses with 1/2/3/4. Release tx_busy -> 'l','1','2','3' emitted with gaps of at least one cycle.
6. Assert rst after "a12" -> all outputs 0. Then "l0000"+0x0d: no ld_alarm, ld_time pulses.
